// File: rtl/bomb_pkg.sv
// bomb_pkg: constants shared by the bomb-dismantlement game controller.
//   - FSM state encodings (3-bit, kept as plain constants so LED/debug
//     tooling that decodes state_o keeps working)
//   - digit underflow marker reported by the countdown stage
//   - BCD digit width and the default secret code
package bomb_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] DIGIT_UNDERFLOW = 4'hF;
    localparam logic [BCD_W-1:0] BCD_MAX         = 4'd9;

    localparam logic [4*BCD_W-1:0] CODE_DEFAULT = 16'h1234;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARMED    = 3'd1;
    localparam logic [2:0] ST_CHECK    = 3'd2;
    localparam logic [2:0] ST_DEFUSED  = 3'd3;
    localparam logic [2:0] ST_EXPLODED = 3'd4;

endpackage

// File: rtl/btn_pulse.sv
// btn_pulse: debounces one raw push button and emits a single-cycle pulse
// per press.
//   clk   - system clock
//   rst   - asynchronous reset, active-low
//   raw   - raw button level, active-high
//   pulse - one-cycle pulse, DEBOUNCE_CYCLES+1 clocks after a stable press
module btn_pulse #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          pulse_reg;
    logic          level_next;

    // Debounced level is asserted once the stable-high run reaches the limit;
    // the counter saturates there so a held button stays at that level.
    assign level_next = (cnt_reg == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            if (!raw)
                cnt_reg <= '0;
            else if (cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + 1'b1;
            level_reg <= level_next;
            pulse_reg <= level_next & ~level_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/defuse_ctrl.sv
// defuse_ctrl: game controller ahead of the 20-second countdown stage.
// Debounces arm/enter buttons, collects a 4-digit BCD code, watches the
// countdown digits for expiry and reports defused/exploded.
//   clk, rst          - clock and asynchronous active-low reset
//   btn_arm/btn_enter - raw push buttons
//   sw_digit          - BCD digit, sampled on an enter pulse
//   s1, s2            - countdown digits; both 4'hF means time ran out
//   start             - enables the countdown
//   success, boom     - outcome flags (mutually exclusive)
//   tries_left        - remaining wrong attempts
//   digit_cnt         - digits entered in the current attempt
//   state_o           - FSM state encoding
module defuse_ctrl
    import bomb_pkg::*;
#(
    parameter logic [15:0] CODE            = CODE_DEFAULT,
    parameter int          DEBOUNCE_CYCLES = 20,
    parameter int          MAX_TRIES       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_arm,
    input  logic             btn_enter,
    input  logic [BCD_W-1:0] sw_digit,
    input  logic [BCD_W-1:0] s1,
    input  logic [BCD_W-1:0] s2,
    output logic             start,
    output logic             success,
    output logic             boom,
    output logic [1:0]       tries_left,
    output logic [2:0]       digit_cnt,
    output logic [2:0]       state_o
);

    localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);

    logic        arm_pulse, enter_pulse, expired;
    logic [2:0]  state_reg, state_next;
    logic [15:0] code_buf_reg, code_buf_next;
    logic [2:0]  digit_cnt_reg, digit_cnt_next;
    logic [1:0]  tries_reg, tries_next;
    logic        start_reg, success_reg, boom_reg;

    btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arm_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_arm),
        .pulse (arm_pulse)
    );

    btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_enter),
        .pulse (enter_pulse)
    );

    assign expired = (s1 == DIGIT_UNDERFLOW) && (s2 == DIGIT_UNDERFLOW);

    always_comb begin
        state_next     = state_reg;
        code_buf_next  = code_buf_reg;
        digit_cnt_next = digit_cnt_reg;
        tries_next     = tries_reg;
        case (state_reg)
            ST_IDLE: begin
                if (arm_pulse) begin
                    state_next     = ST_ARMED;
                    code_buf_next  = '0;
                    digit_cnt_next = '0;
                    tries_next     = TRIES_INIT;
                end
            end
            ST_ARMED: begin
                // Expiry beats everything, including a digit landing this cycle.
                if (expired) begin
                    state_next = ST_EXPLODED;
                end else if (digit_cnt_reg == 3'd4) begin
                    state_next = ST_CHECK;
                end else if (enter_pulse && (sw_digit <= BCD_MAX)) begin
                    code_buf_next  = {code_buf_reg[11:0], sw_digit};
                    digit_cnt_next = digit_cnt_reg + 3'd1;
                end
            end
            ST_CHECK: begin
                if (expired) begin
                    state_next = ST_EXPLODED;
                end else if (code_buf_reg == CODE) begin
                    state_next = ST_DEFUSED;
                end else if (tries_reg > 2'd1) begin
                    state_next     = ST_ARMED;
                    tries_next     = tries_reg - 2'd1;
                    code_buf_next  = '0;
                    digit_cnt_next = '0;
                end else begin
                    state_next = ST_EXPLODED;
                    tries_next = 2'd0;
                end
            end
            ST_DEFUSED, ST_EXPLODED: begin
                if (arm_pulse)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output flags are decoded from the next state so they register on the
    // same edge as the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            code_buf_reg  <= '0;
            digit_cnt_reg <= '0;
            tries_reg     <= TRIES_INIT;
            start_reg     <= 1'b0;
            success_reg   <= 1'b0;
            boom_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            code_buf_reg  <= code_buf_next;
            digit_cnt_reg <= digit_cnt_next;
            tries_reg     <= tries_next;
            start_reg     <= (state_next != ST_IDLE);
            success_reg   <= (state_next == ST_DEFUSED);
            boom_reg      <= (state_next == ST_EXPLODED);
        end
    end

    assign start      = start_reg;
    assign success    = success_reg;
    assign boom       = boom_reg;
    assign tries_left = tries_reg;
    assign digit_cnt  = digit_cnt_reg;
    assign state_o    = state_reg;

endmodule
